// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B.
// Optional transfer counters are enabled with `define MUX_ARB_CNT_EN.

module mux_2x1 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SEL,
   output logic [WIDTH-1:0] Y
);
   assign Y = SEL ? B : A;
endmodule

module mux_2x1_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ_A,
   input  logic [WIDTH-1:0] A,
   output logic             GNT_A,
   input  logic             REQ_B,
   input  logic [WIDTH-1:0] B,
   output logic             GNT_B,
   output logic [WIDTH-1:0] Y,
   output logic             VALID,
   input  logic             READY,
   output logic             SEL
`ifdef MUX_ARB_CNT_EN
   ,
   output logic [CNT_W-1:0] CNT_A,
   output logic [CNT_W-1:0] CNT_B
`endif
);

   logic [WIDTH-1:0] y_q, y_d;
   logic             valid_q, valid_d;
   logic             sel_q, sel_d;
   logic             last_q, last_d;

   logic             open_w;
   logic             both_w;
   logic             win_a_w;
   logic             win_b_w;
   logic             xfer_w;
   logic [WIDTH-1:0] mux_y_w;

   assign open_w  = !valid_q | READY;
   assign both_w  = REQ_A & REQ_B;
   // On contention the requester not served last wins.
   assign win_a_w = open_w & (both_w ? last_q  : REQ_A);
   assign win_b_w = open_w & (both_w ? !last_q : REQ_B);
   assign xfer_w  = win_a_w | win_b_w;

   assign GNT_A = win_a_w;
   assign GNT_B = win_b_w;

   mux_2x1 #(.WIDTH(WIDTH)) u_mux (
      .A   (A),
      .B   (B),
      .SEL (win_b_w),
      .Y   (mux_y_w)
   );

   always_comb begin
      y_d     = y_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      last_d  = last_q;
      if (xfer_w) begin
         y_d     = mux_y_w;
         valid_d = 1'b1;
         sel_d   = win_b_w;
         last_d  = win_b_w;
      end else if (valid_q & READY) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         y_q     <= '0;
         valid_q <= 1'b0;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         y_q     <= y_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

   assign Y     = y_q;
   assign VALID = valid_q;
   assign SEL   = sel_q;

`ifdef MUX_ARB_CNT_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   // Counters stick at all ones instead of wrapping.
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (win_a_w && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
      if (win_b_w && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign CNT_A = cnt_a_q;
   assign CNT_B = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Scoreboard bench for mux_2x1_arbiter: stimulus queues expected words,
// a monitor pops them as the consumer takes each word.

module tb_mux_2x1_arbiter;

`ifdef MUX_ARB_CNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       REQ_A = 1'b0;
   logic [7:0] A = '0;
   logic       GNT_A;
   logic       REQ_B = 1'b0;
   logic [7:0] B = '0;
   logic       GNT_B;
   logic [7:0] Y;
   logic       VALID;
   logic       READY = 1'b0;
   logic       SEL;
`ifdef MUX_ARB_CNT_EN
   logic [CW-1:0] CNT_A;
   logic [CW-1:0] CNT_B;
`endif

   int errors = 0;
   int checks = 0;
   logic [8:0] sb[$];

   mux_2x1_arbiter #(.WIDTH(8), .CNT_W(CW)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .REQ_A (REQ_A),
      .A     (A),
      .GNT_A (GNT_A),
      .REQ_B (REQ_B),
      .B     (B),
      .GNT_B (GNT_B),
      .Y     (Y),
      .VALID (VALID),
      .READY (READY),
      .SEL   (SEL)
`ifdef MUX_ARB_CNT_EN
      ,
      .CNT_A (CNT_A),
      .CNT_B (CNT_B)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic step(input logic ra, input logic [7:0] a,
                       input logic rb, input logic [7:0] b,
                       input logic rdy);
      @(posedge CLK);
      #1;
      REQ_A = ra; A = a; REQ_B = rb; B = b; READY = rdy;
      #1;
   endtask

   task automatic gnt(input string nm, input logic ga, input logic gb);
      chk({nm, "_gnt_a"}, {15'd0, GNT_A}, {15'd0, ga});
      chk({nm, "_gnt_b"}, {15'd0, GNT_B}, {15'd0, gb});
   endtask

   // Monitor: a word is delivered at the coming edge when VALID & READY.
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST && VALID && READY) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got y=%h sel=%b expected none",
                        Y, SEL);
            end else begin
               logic [8:0] e;
               e = sb.pop_front();
               chk("mon_y",   {8'd0, Y},    {8'd0, e[7:0]});
               chk("mon_sel", {15'd0, SEL}, {15'd0, e[8]});
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // Reset asserted mid-cycle, checked before the next edge.
      step(0, 8'h00, 0, 8'h00, 0);
      #1 RST = 1'b1;
      #1;
      chk("rst_y",     {8'd0, Y},      16'h0000);
      chk("rst_valid", {15'd0, VALID}, 16'h0000);
      chk("rst_sel",   {15'd0, SEL},   16'h0000);
      gnt("rst", 0, 0);
      RST = 1'b0;

      // Single requester A.
      step(1, 8'h55, 0, 8'h00, 1);
      gnt("single_a", 1, 0);
      sb.push_back({1'b0, 8'h55});
      // Single requester B; LAST becomes B.
      step(0, 8'h00, 1, 8'h33, 1);
      chk("single_valid", {15'd0, VALID}, 16'h0001);
      chk("single_y",     {8'd0, Y},      16'h0055);
      gnt("single_b", 0, 1);
      sb.push_back({1'b1, 8'h33});

      // Contention: A, B, A, B.
      for (int i = 0; i < 4; i++) begin
         step(1, 8'h55, 1, 8'hAA, 1);
         gnt("contend", (i % 2) == 0, (i % 2) == 1);
         sb.push_back((i % 2) == 0 ? {1'b0, 8'h55} : {1'b1, 8'hAA});
      end

      // Backpressure with AA held in Y.
      for (int i = 0; i < 3; i++) begin
         step(1, 8'h55, 1, 8'hAA, 0);
         gnt("bp", 0, 0);
         chk("bp_y",     {8'd0, Y},      16'h00AA);
         chk("bp_valid", {15'd0, VALID}, 16'h0001);
      end
      // Release: drain AA and capture 55 at the same edge.
      step(1, 8'h55, 1, 8'hAA, 1);
      gnt("bp_release", 1, 0);
      sb.push_back({1'b0, 8'h55});
      step(1, 8'h55, 1, 8'hAA, 1);
      chk("bp_next_y", {8'd0, Y}, 16'h0055);
      gnt("bp_next", 0, 1);
      sb.push_back({1'b1, 8'hAA});

      // Reset with AA stalled in the output register.
      step(0, 8'h00, 0, 8'h00, 0);
      chk("pre_rst_y", {8'd0, Y}, 16'h00AA);
      #1 RST = 1'b1;
      #1;
      chk("mid_rst_valid", {15'd0, VALID}, 16'h0000);
      chk("mid_rst_y",     {8'd0, Y},      16'h0000);
      sb.delete();
      RST = 1'b0;
      step(1, 8'h11, 1, 8'h22, 1);
      gnt("post_rst", 1, 0);
      sb.push_back({1'b0, 8'h11});
      step(0, 8'h00, 0, 8'h00, 1);
      gnt("idle", 0, 0);
      step(0, 8'h00, 0, 8'h00, 1);
      chk("final_valid", {15'd0, VALID}, 16'h0000);

`ifdef MUX_ARB_CNT_EN
      #1 RST = 1'b1;
      #1 RST = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(0, 8'h00, 1, 8'(i), 1);
         sb.push_back({1'b1, 8'(i)});
      end
      step(0, 8'h00, 0, 8'h00, 1);
      chk("cnt_b", {12'd0, CNT_B}, 16'h000F);
      chk("cnt_a", {12'd0, CNT_A}, 16'h0000);
      step(0, 8'h00, 0, 8'h00, 1);
`endif

      chk("sb_empty", 16'(sb.size()), 16'h0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
